// File: rtl/core_pkg.sv
// Shared definitions for the fetch-stage PC generator and its helpers.
// Holds the default address width, reset vector and the BOOT/RUN state type.
package core_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    ST_BOOT,
    ST_RUN
  } state_t;

endpackage

// File: rtl/redir_arb.sv
// Fixed-priority redirect arbiter; source 0 has the highest priority.
// Purely combinational: reports a hit, the winning target and the winner index.
module redir_arb
  import core_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0]      valid,
  input  logic [NUM_SRC*XLEN-1:0] target,
  output logic                    hit,
  output logic [XLEN-1:0]         win_target,
  output logic [IDX_W-1:0]        win_idx
);

  // Scanning from the top down lets the lowest asserted index overwrite the rest.
  always_comb begin
    hit        = 1'b0;
    win_target = '0;
    win_idx    = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (valid[i]) begin
        hit        = 1'b1;
        win_target = target[i*XLEN +: XLEN];
        win_idx    = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/pc_next_unit.sv
// Fetch-stage program-counter generator: sequential advance, prioritised redirects,
// stall-time redirect latching and misaligned-target rejection.
module pc_next_unit
  import core_pkg::*;
#(
  parameter int               XLEN         = XLEN_DEFAULT,
  parameter int               NUM_SRC      = 4,
  parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT),
  parameter int               INC          = 4,
  parameter int               ALIGN_BITS   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_SRC-1:0]      redir_valid,
  input  logic [NUM_SRC*XLEN-1:0] redir_target,
  input  logic                    fetch_ready,
  output logic [XLEN-1:0]         pc,
  output logic                    pc_valid,
  output logic [XLEN-1:0]         pc_inc,
  output logic                    redir_pending,
  output logic                    misalign,
  output logic [XLEN-1:0]         misalign_addr
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  // A zero ALIGN_BITS yields an all-zero mask, which disables the check.
  localparam logic [XLEN-1:0] ALIGN_MASK = (XLEN'(1) << ALIGN_BITS) - XLEN'(1);

  state_t state_q, state_d;

  logic            hit;
  logic [XLEN-1:0] win_target;
  logic [IDX_W-1:0] win_idx;
  logic            aligned, good_hit, bad_hit, accept;
  logic [XLEN-1:0] pend_target;

  redir_arb #(
    .NUM_SRC (NUM_SRC),
    .XLEN    (XLEN),
    .IDX_W   (IDX_W)
  ) u_arb (
    .valid      (redir_valid),
    .target     (redir_target),
    .hit        (hit),
    .win_target (win_target),
    .win_idx    (win_idx)
  );

  assign aligned  = ~|(win_target & ALIGN_MASK);
  assign good_hit = hit & aligned;
  assign bad_hit  = hit & ~aligned;
  assign pc_valid = (state_q == ST_RUN);
  assign accept   = pc_valid & fetch_ready;
  assign pc_inc   = pc + XLEN'(INC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_BOOT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_BOOT) state_d = ST_RUN;
  end

  // A fresh aligned redirect supersedes any pending one, whether accepted or latched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc            <= RESET_VECTOR;
      pend_target   <= '0;
      redir_pending <= 1'b0;
    end else if (accept) begin
      if (good_hit) begin
        pc            <= win_target;
        redir_pending <= 1'b0;
      end else if (redir_pending) begin
        pc            <= pend_target;
        redir_pending <= 1'b0;
      end else begin
        pc <= pc_inc;
      end
    end else if (good_hit) begin
      pend_target   <= win_target;
      redir_pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign      <= 1'b0;
      misalign_addr <= '0;
    end else begin
      misalign <= bad_hit;
      if (bad_hit) misalign_addr <= win_target;
    end
  end

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit: reset, sequential fetch, priority, stall latching,
// misalignment, wrap-around and reset discarding a pending redirect.
module tb_pc_next_unit;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   redir_valid;
  logic [127:0] redir_target;
  logic         fetch_ready;
  logic [31:0]  pc;
  logic         pc_valid;
  logic [31:0]  pc_inc;
  logic         redir_pending;
  logic         misalign;
  logic [31:0]  misalign_addr;

  int total = 0;
  int bad   = 0;

  pc_next_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .redir_valid   (redir_valid),
    .redir_target  (redir_target),
    .fetch_ready   (fetch_ready),
    .pc            (pc),
    .pc_valid      (pc_valid),
    .pc_inc        (pc_inc),
    .redir_pending (redir_pending),
    .misalign      (misalign),
    .misalign_addr (misalign_addr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then settle just past the edge before sampling.
  task automatic applyStimulus(input logic [3:0] valid, input logic ready);
    redir_valid = valid;
    fetch_ready = ready;
    @(posedge clk);
    #1;
  endtask

  task automatic set_target(input int src, input logic [31:0] addr);
    redir_target[src*32 +: 32] = addr;
  endtask

  initial begin
    rst_n        = 1'b0;
    redir_valid  = 4'b0;
    redir_target = '0;
    fetch_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_pc", pc, 32'h0);
    checkOutput("rst_valid", {31'b0, pc_valid}, 32'h0);
    checkOutput("rst_pending", {31'b0, redir_pending}, 32'h0);
    checkOutput("rst_misalign", {31'b0, misalign}, 32'h0);
    checkOutput("rst_misaddr", misalign_addr, 32'h0);

    rst_n = 1'b1;
    #1;
    checkOutput("boot_valid", {31'b0, pc_valid}, 32'h0);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("run_valid", {31'b0, pc_valid}, 32'h1);
    checkOutput("run_pc0", pc, 32'h0);
    checkOutput("pc_inc0", pc_inc, 32'h4);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("seq_pc4", pc, 32'h4);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("seq_pc8", pc, 32'h8);

    set_target(1, 32'h100);
    set_target(2, 32'h200);
    applyStimulus(4'b0110, 1'b1);
    checkOutput("prio_pc", pc, 32'h100);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("prio_drop", pc, 32'h104);

    set_target(0, 32'h40);
    applyStimulus(4'b0001, 1'b1);
    checkOutput("goto_40", pc, 32'h40);
    set_target(0, 32'h80);
    applyStimulus(4'b0001, 1'b0);
    checkOutput("stall1_pc", pc, 32'h40);
    checkOutput("stall1_pend", {31'b0, redir_pending}, 32'h1);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(4'b0000, 1'b0);
      checkOutput("stall_pc", pc, 32'h40);
      checkOutput("stall_pend", {31'b0, redir_pending}, 32'h1);
    end
    applyStimulus(4'b0000, 1'b1);
    checkOutput("release_pc", pc, 32'h80);
    checkOutput("release_pend", {31'b0, redir_pending}, 32'h0);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("after_pend", pc, 32'h84);

    set_target(2, 32'h102);
    applyStimulus(4'b0100, 1'b1);
    checkOutput("mis_flag", {31'b0, misalign}, 32'h1);
    checkOutput("mis_addr", misalign_addr, 32'h102);
    checkOutput("mis_pc", pc, 32'h88);
    checkOutput("mis_pend", {31'b0, redir_pending}, 32'h0);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("mis_pulse", {31'b0, misalign}, 32'h0);
    checkOutput("mis_seq", pc, 32'h8c);

    set_target(1, 32'h10a);
    set_target(2, 32'h200);
    applyStimulus(4'b0110, 1'b1);
    checkOutput("mis_nosub_flag", {31'b0, misalign}, 32'h1);
    checkOutput("mis_nosub_addr", misalign_addr, 32'h10a);
    checkOutput("mis_nosub_pc", pc, 32'h90);

    set_target(3, 32'hffff_fffc);
    applyStimulus(4'b1000, 1'b1);
    checkOutput("wrap_top", pc, 32'hffff_fffc);
    checkOutput("wrap_inc", pc_inc, 32'h0);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("wrap_pc", pc, 32'h0);

    set_target(3, 32'h300);
    applyStimulus(4'b1000, 1'b0);
    checkOutput("pend300", {31'b0, redir_pending}, 32'h1);
    redir_valid = 4'b0000;
    rst_n = 1'b0;
    #1;
    checkOutput("async_pc", pc, 32'h0);
    checkOutput("async_pend", {31'b0, redir_pending}, 32'h0);
    checkOutput("async_valid", {31'b0, pc_valid}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    checkOutput("reboot_valid", {31'b0, pc_valid}, 32'h0);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("reboot_pc", pc, 32'h0);
    checkOutput("reboot_run", {31'b0, pc_valid}, 32'h1);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("reboot_seq", pc, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_next_unit.md
# pc_next_unit

Parametrised program-counter generator for the core's fetch stage. It holds the architectural fetch PC, advances it sequentially on each accepted fetch, and selects among NUM_SRC prioritised redirect sources (branch, jump, trap, return). Redirects arriving during a fetch stall are latched and applied later, never lost. It replaces the two-input next-PC select in front of the instruction memory and drives the fetch address with a valid/ready handshake.

## Interface
- XLEN, 32, address width.
- NUM_SRC, 4, number of redirect sources; index 0 has highest priority.
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset (XLEN bits).
- INC, 4, sequential increment in bytes.
- ALIGN_BITS, 2, low target bits that must be zero; 0 disables the alignment check.

- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- redir_valid  in  NUM_SRC  per-source redirect request, single-cycle pulse.
- redir_target  in  NUM_SRC*XLEN  packed targets; source i occupies [i*XLEN +: XLEN].
- fetch_ready  in  1  fetch stage accepts pc this cycle.
- pc  out  XLEN  current fetch address.
- pc_valid  out  1  pc is presented for fetch.
- pc_inc  out  XLEN  pc + INC, combinational from pc, for link-register use.
- redir_pending  out  1  a latched redirect awaits a handshake.
- misalign  out  1  one-cycle pulse: a rejected misaligned redirect.
- misalign_addr  out  XLEN  offending target, valid while misalign is 1.

## Operation
- States: BOOT (pc = RESET_VECTOR, pc_valid = 0) and RUN (pc_valid = 1). BOOT -> RUN on the first clock edge with rst_n high. RUN is left only by reset.
- Handshake: a fetch is accepted when pc_valid & fetch_ready. Without acceptance, pc holds its value.
- Winner selection: the lowest-index asserted redir_valid wins. Other sources in the same cycle are dropped.
- Alignment: a winner whose target[ALIGN_BITS-1:0] != 0 is rejected. The next edge sets misalign = 1 and misalign_addr = target. Pending and pc are unaffected by a rejected redirect. Only the winner is checked; a lower-priority aligned source is not substituted.
- Next pc on an accepted fetch, by priority:
  1. Aligned winner this cycle.
  2. Otherwise, the pending target; pending is then cleared.
  3. Otherwise, pc + INC.
- Stall (RUN, fetch_ready = 0) with an aligned winner: store the target in the pending register and set redir_pending. A newer redirect overwrites an older pending one.
- Redirects in BOOT: treat as in a stall (latched to pending).
- Arithmetic: pc + INC is modulo 2^XLEN. XLEN'hFFFF_FFFC + 4 wraps to 0 with no flag.

## Timing
- Reset values: pc = RESET_VECTOR, pc_valid = 0, redir_pending = 0, misalign = 0, misalign_addr = 0, pending register = 0.
- Redirect-to-pc latency: 1 cycle when fetch_ready = 1 in the redirect cycle. Otherwise the redirect takes effect on the first accepting edge.
- pc is stable whenever pc_valid & !fetch_ready. The stale pc is accepted before the redirect applies; the downstream flush handles it.
- misalign rises exactly 1 cycle after the offending redir_valid and lasts 1 cycle.
- rst_n low mid-operation: all state clears asynchronously, and pending redirects are discarded. On release, BOOT lasts one cycle.

## Structure
- Shared package core_pkg: XLEN default, RESET_VECTOR default, state enum {ST_BOOT, ST_RUN}.
- Sub-module redir_arb: combinational fixed-priority arbiter over NUM_SRC. Outputs are hit, winning target and winner index.
- Top level: BOOT/RUN state flop, pc register, pending register with valid bit, misalign flops.

## Test plan
- Reset release, fetch_ready = 1: pc_valid = 0 for 1 cycle at 0x0. Then pc = 0x0, 0x4, 0x8 on successive edges.
- fetch_ready = 1, redir_valid = 4'b0110 with targets src1 = 0x100, src2 = 0x200 -> next pc = 0x100; src2 is dropped.
- Stall, branch the same cycle:
  - Stimulus: fetch_ready = 0 at pc = 0x40; redir_valid[0] = 1, target 0x80.
  - Hold: pc stays 0x40 and redir_pending = 1 for 3 stall cycles.
  - Release: fetch_ready = 1 -> pc = 0x80 and redir_pending = 0.
- Misaligned target 0x102 on source 2 -> misalign pulses 1 cycle with misalign_addr = 0x102; pc continues sequentially.
- pc = 0xFFFF_FFFC, accepted fetch -> pc = 0x0.
- Pending set (target 0x300), then rst_n asserted for 2 cycles -> pc = RESET_VECTOR, redir_pending = 0; after release, fetch starts at RESET_VECTOR, not 0x300.
